cache_fill_ctrl: RTL and testbench
==================================

# cache_fill_ctrl

Parametrised successor to the single-block cache fill FSM. It services one cache-line miss at a time and issues one pipelined word-read request per cycle to the multi-cycle memory. It counts returning words independently of issued requests and generates data-array and tag-array write strobes. It supports optional critical-word-first ordering, and sits between the cache tag-match logic and the unified memory model, with `fsm_busy` driving the pipeline stall.

## Interface
- `ADDR_W`, 16: address width in bits.
- `WORD_BYTES`, 2: bytes per memory word; power of two.
- `BLOCK_WORDS`, 8: words per cache block; power of two, ≥2.
- `CWF`, 0: 0 fetches from word 0 upward; 1 fetches the missed word first, then wraps.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `miss_detected`  in  1  tag-match miss; sampled only in IDLE.
- `miss_address`  in  ADDR_W  address that missed; sampled with `miss_detected` in IDLE.
- `memory_data_valid`  in  1  valid read data on memory bus this cycle.
- `fsm_busy`  out  1  high while a fill is in progress (stall).
- `mem_req`  out  1  read request to memory this cycle.
- `memory_address`  out  ADDR_W  word address of current request; 0 when `mem_req`=0.
- `data_wen`  out  1  write returning word into the data array.
- `data_addr`  out  ADDR_W  address of the word being written; 0 when `data_wen`=0.
- `tag_wen`  out  1  write tag/valid for the block; one-cycle pulse.
- `fill_done`  out  1  one-cycle pulse coincident with the final `data_wen`.

## Operation
- Derived widths:
  - `OFF_W` = log2(BLOCK_WORDS·WORD_BYTES).
  - `IDX_W` = log2(BLOCK_WORDS).
  - `LSB_W` = log2(WORD_BYTES).
- States: IDLE, FILL.
- IDLE, `miss_detected`=1:
  - Latch `base` = `miss_address` with low `OFF_W` bits cleared.
  - Latch `start` = CWF ? `miss_address[OFF_W-1:LSB_W]` : 0.
  - Clear issue counter `ic` and return counter `rc`.
  - Next state FILL.
- IDLE, `miss_detected`=0: remain in IDLE. `memory_data_valid` is ignored in IDLE.
- FILL, issue side:
  - `mem_req`=1 while `ic` < BLOCK_WORDS.
  - `memory_address` = `base` | (((`start`+`ic`) mod BLOCK_WORDS) << LSB_W).
  - `ic` increments each requesting cycle and saturates at BLOCK_WORDS.
- FILL, return side, on `memory_data_valid`=1:
  - `data_wen`=1.
  - `data_addr` = `base` | (((`start`+`rc`) mod BLOCK_WORDS) << LSB_W).
  - `rc` increments.
- Completion: valid with `rc`=BLOCK_WORDS-1 asserts `tag_wen`=1 and `fill_done`=1 that cycle; next state IDLE.
- Index arithmetic is IDX_W bits wide with natural wrap, so the mod is implicit. Counters are IDX_W+1 bits.
- `fsm_busy` = (state==FILL). `miss_detected` is ignored while in FILL.
- Valids arriving before the first request are not expected; the memory model guarantees returns lag requests by ≥1 cycle.

## Timing
- Reset: state IDLE, counters 0, `base`/`start` 0. All outputs are 0 in the cycle after `rst` is sampled high.
- Reset mid-fill: fill is abandoned with no `tag_wen`. Outstanding memory returns after reset land in IDLE and are ignored.
- Miss accepted at edge N. The following occur during cycle N+1:
  - FILL entered and `fsm_busy`=1.
  - First `mem_req`.
- Requests occupy cycles N+1..N+BLOCK_WORDS back-to-back, with no gaps.
- Returns are in order. Gaps in `memory_data_valid` stall only `rc`; `ic` is unaffected.
- Cycle of last valid: `data_wen`, `tag_wen`, `fill_done` and `fsm_busy` are all 1.
- Next cycle: IDLE, `fsm_busy`=0.
- A miss re-presented in that IDLE cycle is accepted. A miss asserted during the completion cycle is ignored; the tag logic re-presents it.
- Back-to-back fills: minimum one IDLE cycle between FILL periods.
- Outputs are combinational from registered state/counters plus `memory_data_valid`. There is no combinational path from `miss_detected`/`miss_address` to any output.

## Test plan
- **Default params, 4-cycle memory (valid 4 cycles after each req), miss at 0x1234, CWF=0:**
  - `mem_req` cycles 1–8 with addresses 0x1230, 0x1232 … 0x123E.
  - `data_wen` cycles 5–12 with the same address order.
  - `tag_wen`/`fill_done` in cycle 12; `fsm_busy` 1 for cycles 1–12, 0 in cycle 13.
- **CWF=1, miss 0x123A:** request order 0x123A, 0x123C, 0x123E, 0x1230 … 0x1238; `data_addr` follows the same order.
- **Gapped returns (valid dropped for 3 cycles mid-block):** exactly 8 `data_wen`; `fill_done` only on the 8th; `fsm_busy` held until then.
- **`miss_detected` toggled with other addresses during FILL:** ignored. Latched `base` is unchanged and no extra requests are issued.
- **`rst` asserted after the 3rd return:**
  - Next cycle all outputs are 0 and the state is IDLE.
  - Later stray valids produce no `data_wen`.
  - A new miss starts a clean fill from word 0.
- **`BLOCK_WORDS`=4, `WORD_BYTES`=4, `ADDR_W`=32, miss 0x0000_00F4:**
  - Requests to 0xF0, 0xF4, 0xF8, 0xFC.
  - `fill_done` after the 4th valid.
  - A miss held high through the completion cycle is accepted in the following IDLE cycle.

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_fill_ctrl
//
// Cache-line fill sequencer. It accepts one miss at a time from the tag-match
// logic, then issues one pipelined word-read per cycle to the memory. It
// counts returning words separately from issued requests. For each returning
// word it produces a data-array write strobe. The tag-array write strobe
// fires on the final word. With CWF=1 the missed word is fetched first and
// the sequence wraps around the block.
//
// Parameters
//   ADDR_W       address width in bits
//   WORD_BYTES   bytes per memory word (power of two)
//   BLOCK_WORDS  words per cache block (power of two, >= 2)
//   CWF          0: word 0 first; 1: missed word first, then wrap
//
// Ports
//   clk                in   system clock, all state updates on rising edge
//   rst                in   synchronous active-high reset
//   miss_detected      in   tag-match miss, only looked at while idle
//   miss_address       in   missing address, captured with miss_detected
//   memory_data_valid  in   read data present on the memory bus this cycle
//   fsm_busy           out  fill in progress (pipeline stall)
//   mem_req            out  read request this cycle
//   memory_address     out  word address of the request, 0 when idle
//   data_wen           out  write the returning word into the data array
//   data_addr          out  address of the word being written, 0 when idle
//   tag_wen            out  tag/valid write, one-cycle pulse on the last word
//   fill_done          out  one-cycle pulse coincident with the last data_wen
// -----------------------------------------------------------------------------
module cache_fill_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WORD_BYTES  = 2,
    parameter int BLOCK_WORDS = 8,
    parameter int CWF         = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic              memory_data_valid,
    output logic              fsm_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] memory_address,
    output logic              data_wen,
    output logic [ADDR_W-1:0] data_addr,
    output logic              tag_wen,
    output logic              fill_done
);

    // Byte-offset width of a block, word-index width, and byte-in-word width.
    localparam int OFF_W = $clog2(BLOCK_WORDS * WORD_BYTES);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int LSB_W = $clog2(WORD_BYTES);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    // Return count at which the arriving word is the last of the block.
    localparam logic [IDX_W:0] LAST_RC = (IDX_W + 1)'(BLOCK_WORDS - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] base;      // block-aligned address of the line being filled
    logic [IDX_W-1:0]  start;     // word index fetched first
    logic [IDX_W:0]    ic;        // requests issued, saturates at BLOCK_WORDS
    logic [IDX_W:0]    rc;        // words returned

    logic              in_fill;
    logic              last_beat;
    logic [IDX_W-1:0]  miss_idx;
    logic [IDX_W-1:0]  issue_idx;
    logic [IDX_W-1:0]  ret_idx;
    logic [ADDR_W-1:0] miss_base;

    // The byte-in-word bits of the miss address never affect the fill; fold
    // the whole address here so those bits are visibly consumed.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^miss_address;

    assign miss_idx  = miss_address[OFF_W-1:LSB_W];
    assign miss_base = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Word indices are IDX_W bits wide, so start+count wraps around the
    // block without an explicit modulo.
    assign issue_idx = start + ic[IDX_W-1:0];
    assign ret_idx   = start + rc[IDX_W-1:0];

    assign in_fill = (state == ST_FILL);

    // NOTE: every output is a continuous assignment covering all cases, so no
    // output can hold a stale value (no latch) and none depends on the miss inputs.
    assign fsm_busy       = in_fill;
    // ic stops at BLOCK_WORDS (= 1 << IDX_W), so its MSB marks "all issued".
    assign mem_req        = in_fill && !ic[IDX_W];
    assign memory_address = mem_req ? (base | (ADDR_W'(issue_idx) << LSB_W)) : '0;
    // Returns are only meaningful during a fill; stray valids in idle are dropped.
    assign data_wen       = in_fill && memory_data_valid;
    assign data_addr      = data_wen ? (base | (ADDR_W'(ret_idx) << LSB_W)) : '0;
    assign last_beat      = data_wen && (rc == LAST_RC);
    assign tag_wen        = last_beat;
    assign fill_done      = last_beat;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            base  <= '0;
            start <= '0;
            ic    <= '0;
            rc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_detected) begin
                        base  <= miss_base;
                        start <= (CWF != 0) ? miss_idx : '0;
                        ic    <= '0;
                        rc    <= '0;
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Issue and return sides advance independently; a gap in
                    // the returns stalls only rc.
                    if (mem_req) begin
                        ic <= ic + 1'b1;
                    end
                    if (data_wen) begin
                        rc <= rc + 1'b1;
                    end
                    // A miss arriving now is ignored; the tag logic re-presents
                    // it in the idle cycle that follows.
                    if (last_beat) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_ctrl
//
// Three instances are driven from directed stimulus:
//   u0: 16-bit address, 2-byte words, 8-word blocks, linear order
//   u1: same geometry, critical-word-first
//   u2: 32-bit address, 4-byte words, 4-word blocks, linear order
// A block-level model predicts every output of every instance on every
// cycle. Each instance's outputs are also logged per cycle, so that literal
// expectations can be checked against the log afterwards.
// -----------------------------------------------------------------------------
module tb_cache_fill_ctrl;

    localparam int HN = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  miss;
    logic [2:0]  valid;
    logic [31:0] maddr [3];

    logic [2:0]  busy, req, wen, tag, done;
    logic [15:0] ma0, da0, ma1, da1;
    logic [31:0] ma2, da2;
    logic [31:0] o_ma [3];
    logic [31:0] o_da [3];

    assign o_ma[0] = {16'h0000, ma0};
    assign o_da[0] = {16'h0000, da0};
    assign o_ma[1] = {16'h0000, ma1};
    assign o_da[1] = {16'h0000, da1};
    assign o_ma[2] = ma2;
    assign o_da[2] = da2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .CWF(0)) u0 (
        .clk(clk), .rst(rst), .miss_detected(miss[0]), .miss_address(maddr[0][15:0]),
        .memory_data_valid(valid[0]), .fsm_busy(busy[0]), .mem_req(req[0]),
        .memory_address(ma0), .data_wen(wen[0]), .data_addr(da0),
        .tag_wen(tag[0]), .fill_done(done[0])
    );

    cache_fill_ctrl #(.ADDR_W(16), .WORD_BYTES(2), .BLOCK_WORDS(8), .CWF(1)) u1 (
        .clk(clk), .rst(rst), .miss_detected(miss[1]), .miss_address(maddr[1][15:0]),
        .memory_data_valid(valid[1]), .fsm_busy(busy[1]), .mem_req(req[1]),
        .memory_address(ma1), .data_wen(wen[1]), .data_addr(da1),
        .tag_wen(tag[1]), .fill_done(done[1])
    );

    cache_fill_ctrl #(.ADDR_W(32), .WORD_BYTES(4), .BLOCK_WORDS(4), .CWF(0)) u2 (
        .clk(clk), .rst(rst), .miss_detected(miss[2]), .miss_address(maddr[2]),
        .memory_data_valid(valid[2]), .fsm_busy(busy[2]), .mem_req(req[2]),
        .memory_address(ma2), .data_wen(wen[2]), .data_addr(da2),
        .tag_wen(tag[2]), .fill_done(done[2])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // ---------------------------------------------------------------- model
    // A fill is the ordered list of word addresses in the block. Requests
    // walk that list one per cycle. Each valid return consumes the next entry.
    int          m_bw  [3] = '{8, 8, 4};
    int          m_wb  [3] = '{2, 2, 4};
    int          m_cwf [3] = '{0, 1, 0};
    bit          m_busy [3];
    int          m_req  [3];
    int          m_ret  [3];
    logic [31:0] m_seq  [3][8];

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 1'b0;
            m_req[i]  = 0;
            m_ret[i]  = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_busy[i] = 1'b0;
                m_req[i]  = 0;
                m_ret[i]  = 0;
            end else if (!m_busy[i]) begin
                if (miss[i]) begin
                    int a, blk, base_i, first;
                    a      = int'(maddr[i]);
                    blk    = m_bw[i] * m_wb[i];
                    base_i = a - (a % blk);
                    first  = (m_cwf[i] != 0) ? (a % blk) / m_wb[i] : 0;
                    for (int k = 0; k < m_bw[i]; k++)
                        m_seq[i][k] = 32'(base_i + ((first + k) % m_bw[i]) * m_wb[i]);
                    m_busy[i] = 1'b1;
                    m_req[i]  = 0;
                    m_ret[i]  = 0;
                end
            end else begin
                if (m_req[i] < m_bw[i]) m_req[i]++;
                if (valid[i]) begin
                    if (m_ret[i] == m_bw[i] - 1) m_busy[i] = 1'b0;
                    else                         m_ret[i]++;
                end
            end
        end
    end

    // ------------------------------------------------- compare + output log
    logic        h_busy [3][HN];
    logic        h_req  [3][HN];
    logic        h_wen  [3][HN];
    logic        h_tag  [3][HN];
    logic        h_done [3][HN];
    logic [31:0] h_ma   [3][HN];
    logic [31:0] h_da   [3][HN];

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                logic        e_req, e_wen, e_last;
                logic [31:0] e_ma, e_da;
                e_req  = m_busy[i] && (m_req[i] < m_bw[i]);
                e_ma   = e_req ? m_seq[i][m_req[i]] : 32'h0;
                e_wen  = m_busy[i] && valid[i];
                e_da   = e_wen ? m_seq[i][m_ret[i]] : 32'h0;
                e_last = e_wen && (m_ret[i] == m_bw[i] - 1);
                check($sformatf("u%0d.fsm_busy@%0d", i, cyc), 32'(busy[i]), 32'(m_busy[i]));
                check($sformatf("u%0d.mem_req@%0d", i, cyc), 32'(req[i]), 32'(e_req));
                check($sformatf("u%0d.memory_address@%0d", i, cyc), o_ma[i], e_ma);
                check($sformatf("u%0d.data_wen@%0d", i, cyc), 32'(wen[i]), 32'(e_wen));
                check($sformatf("u%0d.data_addr@%0d", i, cyc), o_da[i], e_da);
                check($sformatf("u%0d.tag_wen@%0d", i, cyc), 32'(tag[i]), 32'(e_last));
                check($sformatf("u%0d.fill_done@%0d", i, cyc), 32'(done[i]), 32'(e_last));
                if (cyc < HN) begin
                    h_busy[i][cyc] = busy[i];
                    h_req[i][cyc]  = req[i];
                    h_wen[i][cyc]  = wen[i];
                    h_tag[i][cyc]  = tag[i];
                    h_done[i][cyc] = done[i];
                    h_ma[i][cyc]   = o_ma[i];
                    h_da[i][cyc]   = o_da[i];
                end
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Present a miss in cycle t0. Then drive memory_data_valid from vpat[c] in
    // cycle t0+c for c = 1..ncyc. With tog set, miss_detected pulses with
    // unrelated addresses while the fill runs.
    task automatic drive_fill(input int i, input logic [31:0] addr, input logic [31:0] vpat,
                              input int ncyc, input bit tog, output int t0);
        t0       = cyc;
        miss[i]  = 1'b1;
        maddr[i] = addr;
        valid[i] = 1'b0;
        step();
        miss[i] = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            valid[i] = vpat[c];
            if (tog) begin
                miss[i]  = (c % 2 == 1) && (c < ncyc - 1);
                maddr[i] = 32'h9990 + 32'(c * 2);
            end
            step();
        end
        valid[i] = 1'b0;
        miss[i]  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, m;
        rst   = 1'b1;
        miss  = '0;
        valid = '0;
        for (int i = 0; i < 3; i++) maddr[i] = 32'h0;

        // Reset state.
        step();
        chk_en = 1'b1;
        check("reset.fsm_busy", 32'(busy), 32'h0);
        check("reset.mem_req", 32'(req), 32'h0);
        check("reset.data_wen", 32'(wen), 32'h0);
        check("reset.tag_wen", 32'(tag | done), 32'h0);
        check("reset.addr_u0", o_ma[0] | o_da[0], 32'h0);
        step();
        rst = 1'b0;
        step();

        // Linear fill, 4-cycle memory, miss at 0x1234.
        drive_fill(0, 32'h1234, 32'h0000_1FE0, 13, 1'b0, t0);
        check("lin.busy_c0", 32'(h_busy[0][t0]), 32'h0);
        check("lin.req_c1", 32'(h_req[0][t0+1]), 32'h1);
        check("lin.addr_c1", h_ma[0][t0+1], 32'h1230);
        check("lin.addr_c2", h_ma[0][t0+2], 32'h1232);
        check("lin.addr_c8", h_ma[0][t0+8], 32'h123E);
        check("lin.req_c9", 32'(h_req[0][t0+9]), 32'h0);
        check("lin.wen_c4", 32'(h_wen[0][t0+4]), 32'h0);
        check("lin.daddr_c5", h_da[0][t0+5], 32'h1230);
        check("lin.daddr_c12", h_da[0][t0+12], 32'h123E);
        check("lin.done_c11", 32'(h_done[0][t0+11]), 32'h0);
        check("lin.done_c12", 32'(h_done[0][t0+12]), 32'h1);
        check("lin.tag_c12", 32'(h_tag[0][t0+12]), 32'h1);
        check("lin.busy_c12", 32'(h_busy[0][t0+12]), 32'h1);
        check("lin.busy_c13", 32'(h_busy[0][t0+13]), 32'h0);

        // Critical word first, miss at 0x123A.
        drive_fill(1, 32'h123A, 32'h0000_1FE0, 13, 1'b0, t0);
        check("cwf.addr_c1", h_ma[1][t0+1], 32'h123A);
        check("cwf.addr_c2", h_ma[1][t0+2], 32'h123C);
        check("cwf.addr_c3", h_ma[1][t0+3], 32'h123E);
        check("cwf.addr_c4", h_ma[1][t0+4], 32'h1230);
        check("cwf.addr_c8", h_ma[1][t0+8], 32'h1238);
        check("cwf.daddr_c5", h_da[1][t0+5], 32'h123A);
        check("cwf.daddr_c8", h_da[1][t0+8], 32'h1230);
        check("cwf.daddr_c12", h_da[1][t0+12], 32'h1238);
        check("cwf.done_c12", 32'(h_done[1][t0+12]), 32'h1);

        // Returns with a 3-cycle hole after the third word.
        drive_fill(0, 32'h1234, 32'h0000_F8E0, 16, 1'b0, t0);
        n = 0;
        m = 0;
        for (int k = 0; k <= 16; k++) begin
            n += int'(h_wen[0][t0+k]);
            m += int'(h_done[0][t0+k]);
        end
        check("gap.wen_count", 32'(n), 32'd8);
        check("gap.done_count", 32'(m), 32'd1);
        check("gap.req_c8", h_ma[0][t0+8], 32'h123E);
        check("gap.busy_c14", 32'(h_busy[0][t0+14]), 32'h1);
        check("gap.done_c15", 32'(h_done[0][t0+15]), 32'h1);
        check("gap.daddr_c15", h_da[0][t0+15], 32'h123E);
        check("gap.busy_c16", 32'(h_busy[0][t0+16]), 32'h0);

        // miss_detected toggled with other addresses during the fill.
        drive_fill(0, 32'h4446, 32'h0000_1FE0, 13, 1'b1, t0);
        n = 0;
        for (int k = 0; k <= 13; k++) n += int'(h_req[0][t0+k]);
        check("tog.req_count", 32'(n), 32'd8);
        check("tog.addr_c1", h_ma[0][t0+1], 32'h4440);
        check("tog.addr_c8", h_ma[0][t0+8], 32'h444E);
        check("tog.daddr_c12", h_da[0][t0+12], 32'h444E);
        check("tog.busy_c13", 32'(h_busy[0][t0+13]), 32'h0);

        // Reset after the third return, then stray returns, then a clean fill.
        t0       = cyc;
        miss[0]  = 1'b1;
        maddr[0] = 32'h1234;
        step();
        miss[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            valid[0] = ((c >= 5) && (c <= 7)) || (c >= 9);
            rst      = (c == 8);
            step();
        end
        valid[0] = 1'b0;
        rst      = 1'b0;
        check("rst.busy_c8", 32'(h_busy[0][t0+8]), 32'h1);
        check("rst.busy_c9", 32'(h_busy[0][t0+9]), 32'h0);
        check("rst.req_c9", 32'(h_req[0][t0+9]), 32'h0);
        check("rst.addr_c9", h_ma[0][t0+9], 32'h0);
        n = 0;
        m = 0;
        for (int k = 9; k <= 12; k++) n += int'(h_wen[0][t0+k]);
        for (int k = 0; k <= 12; k++) m += int'(h_tag[0][t0+k]) + int'(h_done[0][t0+k]);
        check("rst.stray_wen", 32'(n), 32'd0);
        check("rst.no_tag", 32'(m), 32'd0);
        drive_fill(0, 32'h2236, 32'h0000_1FE0, 13, 1'b0, t0);
        check("rst.new_addr_c1", h_ma[0][t0+1], 32'h2230);
        check("rst.new_daddr_c5", h_da[0][t0+5], 32'h2230);
        check("rst.new_done_c12", 32'(h_done[0][t0+12]), 32'h1);

        // 32-bit / 4-word / 4-byte instance. The miss is held high through the
        // completion cycle and accepted again in the idle cycle after it.
        t0       = cyc;
        maddr[2] = 32'h0000_00F4;
        for (int c = 0; c <= 18; c++) begin
            miss[2]  = (c <= 9);
            valid[2] = ((c >= 5) && (c <= 8)) || ((c >= 14) && (c <= 17));
            step();
        end
        miss[2]  = 1'b0;
        valid[2] = 1'b0;
        check("w4.addr_c1", h_ma[2][t0+1], 32'hF0);
        check("w4.addr_c2", h_ma[2][t0+2], 32'hF4);
        check("w4.addr_c3", h_ma[2][t0+3], 32'hF8);
        check("w4.addr_c4", h_ma[2][t0+4], 32'hFC);
        check("w4.req_c5", 32'(h_req[2][t0+5]), 32'h0);
        check("w4.done_c7", 32'(h_done[2][t0+7]), 32'h0);
        check("w4.done_c8", 32'(h_done[2][t0+8]), 32'h1);
        check("w4.busy_c9", 32'(h_busy[2][t0+9]), 32'h0);
        check("w4.busy_c10", 32'(h_busy[2][t0+10]), 32'h1);
        check("w4.readdr_c10", h_ma[2][t0+10], 32'hF0);
        check("w4.done_c17", 32'(h_done[2][t0+17]), 32'h1);
        check("w4.busy_c18", 32'(h_busy[2][t0+18]), 32'h0);

        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
